// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-aligned coordinates, active/blank
// flags, sync pulses, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               vid,
    output logic               vblank,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // h/v address the pixel that the next enable tick will present.
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_last;
    logic             v_last;
    logic             in_hs;
    logic             in_vs;

    always_comb begin
        h_last = (h == H_LAST);
        v_last = (v == V_LAST);
        in_hs  = (h >= HS_FIRST) && (h <= HS_LAST);
        in_vs  = (v >= VS_FIRST) && (v <= VS_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            hcount      <= '0;
            vcount      <= '0;
            vid         <= 1'b0;
            vblank      <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // Strobes drop on every non-tick cycle so they stay one clk wide.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (enable) begin
                hcount      <= h;
                vcount      <= v;
                vid         <= (h < H_VIS) && (v < V_VIS);
                vblank      <= (v >= V_VIS);
                hs          <= in_hs ? HS_POL : ~HS_POL;
                vs          <= in_vs ? VS_POL : ~VS_POL;
                line_start  <= (h == '0);
                frame_start <= (h == '0) && (v == '0);
                if (h_last) begin
                    h <= '0;
                    v <= v_last ? '0 : v + 1'b1;
                    if (v_last) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (opposite sync polarity,
// different frame counter widths) driven by continuous, decimated and random enables.
module tb_vga_timing_gen;

    localparam int CW = 6;

    // instance 0 geometry: 17 x 11 = 187 ticks per frame, active-low sync
    localparam int A_HA = 10, A_HFP = 2, A_HS = 3, A_HBP = 2;
    localparam int A_VA = 6,  A_VFP = 1, A_VS = 2, A_VBP = 2;
    localparam int A_FW = 8;
    // instance 1 geometry: 16 x 10 = 160 ticks per frame, active-high sync
    localparam int B_HA = 8, B_HFP = 1, B_HS = 4, B_HBP = 3;
    localparam int B_VA = 4, B_VFP = 1, B_VS = 2, B_VBP = 3;
    localparam int B_FW = 2;

    localparam logic [31:0] STROBE_MASK = 32'h0003_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic [CW-1:0] hc0, vc0, hc1, vc1;
    logic vid0, vb0, hs0, vs0, ls0, fs0;
    logic vid1, vb1, hs1, vs1, ls1, fs1;
    logic [A_FW-1:0] fc0;
    logic [B_FW-1:0] fc1;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int tick0 = 0;
    int tick1 = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW), .FRAME_W(A_FW)
    ) dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .hcount(hc0), .vcount(vc0), .vid(vid0), .vblank(vb0),
        .hs(hs0), .vs(vs0), .line_start(ls0), .frame_start(fs0),
        .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW), .FRAME_W(B_FW)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .hcount(hc1), .vcount(vc1), .vid(vid1), .vblank(vb1),
        .hs(hs1), .vs(vs1), .line_start(ls1), .frame_start(fs1),
        .frame_cnt(fc1)
    );

    // {fc[7:0], fs, ls, vs, hs, vblank, vid, y[5:0], x[5:0]}
    function automatic logic [31:0] pack(int x, int y, bit vd, bit vb, bit h, bit v,
                                         bit ls, bit fs, int fc);
        return {6'd0, fc[7:0], fs, ls, v, h, vb, vd, y[5:0], x[5:0]};
    endfunction

    // Tick k after reset shows raster pixel k mod frame length; frames completed
    // by the end of tick k is (k+1) / frame length.
    function automatic logic [31:0] model(int k, int ha, int hfp, int hsw, int hbp,
                                          int va, int vfp, int vsw, int vbp,
                                          bit hp, bit vp, int fw);
        int ht, vt, p, x, y, fc;
        bit in_h, in_v;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        p    = k % (ht * vt);
        x    = p % ht;
        y    = p / ht;
        fc   = ((k + 1) / (ht * vt)) % (1 << fw);
        in_h = (x >= ha + hfp) && (x < ha + hfp + hsw);
        in_v = (y >= va + vfp) && (y < va + vfp + vsw);
        return pack(x, y, (x < ha) && (y < va), y >= va,
                    in_h ? hp : !hp, in_v ? vp : !vp, x == 0, (x == 0) && (y == 0), fc);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the expected result of each enable
    // tick is queued here and consumed by the monitor after the rising edge.
    task automatic drive(bit en, bit rst);
        @(negedge clk);
        enable = en;
        reset  = rst;
        if (rst) begin
            tick0 = 0;
            tick1 = 0;
        end else if (en) begin
            exp_q0.push_back(model(tick0, A_HA, A_HFP, A_HS, A_HBP,
                                   A_VA, A_VFP, A_VS, A_VBP, 1'b0, 1'b0, A_FW));
            exp_q1.push_back(model(tick1, B_HA, B_HFP, B_HS, B_HBP,
                                   B_VA, B_VFP, B_VS, B_VBP, 1'b1, 1'b1, B_FW));
            tick0++;
            tick1++;
        end
    endtask

    initial begin : monitor
        logic [31:0] rst0, rst1, last0, last1, exp0, exp1, act0, act1;
        bit r, e;
        rst0  = pack(0, 0, 0, 0, 1'b1, 1'b1, 0, 0, 0);
        rst1  = pack(0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
        last0 = rst0;
        last1 = rst1;
        forever begin
            @(posedge clk);
            r = reset;
            e = enable;
            #1;
            act0 = pack(hc0, vc0, vid0, vb0, hs0, vs0, ls0, fs0, fc0);
            act1 = pack(hc1, vc1, vid1, vb1, hs1, vs1, ls1, fs1, fc1);
            if (r) begin
                exp0 = rst0;
                exp1 = rst1;
            end else if (e) begin
                if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL queue_underflow t=%0t got=empty want=entry", $time);
                    exp0 = last0;
                    exp1 = last1;
                end else begin
                    exp0 = exp_q0.pop_front();
                    exp1 = exp_q1.pop_front();
                end
            end else begin
                exp0 = last0 & ~STROBE_MASK;
                exp1 = last1 & ~STROBE_MASK;
            end
            last0 = exp0;
            last1 = exp1;
            check(r ? "reset0" : (e ? "tick0" : "hold0"), act0, exp0);
            check(r ? "reset1" : (e ? "tick1" : "hold1"), act1, exp1);
        end
    end

    initial begin
        repeat (2) drive(1'b0, 1'b1);
        repeat (10) drive(1'b0, 1'b0);
        // continuous enable across several frames
        repeat (400) drive(1'b1, 1'b0);
        // one tick in four
        repeat (200) begin
            drive(1'b1, 1'b0);
            repeat (3) drive(1'b0, 1'b0);
        end
        // random enable pattern
        repeat (1200) drive(1'($urandom_range(0, 1)), 1'b0);
        // reset mid-frame, with enable also high: reset must win
        repeat (97) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        repeat (350) drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        total++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", exp_q0.size() + exp_q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
